// File: rtl/simplebus_host_if.sv
// simplebus_host_if: Wishbone request/response and external simplebus byte lanes.
//   master modport : seen by simplebus_host (Wishbone inputs, bus outputs)
//   slave  modport : seen by the SoC fabric / external device side
interface simplebus_host_if;
  localparam int unsigned ADR_W  = 32;
  localparam int unsigned DAT_W  = 64;
  localparam int unsigned SEL_W  = 8;
  localparam int unsigned BYTE_W = 8;

  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [ADR_W-1:0]  wb_adr;
  logic [DAT_W-1:0]  wb_dat_w;
  logic [SEL_W-1:0]  wb_sel;
  logic [DAT_W-1:0]  wb_dat_r;
  logic              wb_ack;
  logic              wb_err;
  logic              wb_stall;
  logic [BYTE_W-1:0] ext_bus_out;
  logic              ext_bus_pty_out;
  logic [BYTE_W-1:0] ext_bus_in;
  logic              ext_bus_pty_in;

  modport master (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    output wb_dat_r, wb_ack, wb_err, wb_stall,
    output ext_bus_out, ext_bus_pty_out,
    input  ext_bus_in, ext_bus_pty_in
  );

  modport slave (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    input  wb_dat_r, wb_ack, wb_err, wb_stall,
    input  ext_bus_out, ext_bus_pty_out,
    output ext_bus_in, ext_bus_pty_in
  );
endinterface

// File: rtl/simplebus_host.sv
// simplebus_host: serializes single 64-bit Wishbone requests onto the 8-bit
// simplebus (cmd/addr/sel/data, LSB first, odd-complement parity) and decodes
// the device response into wb_ack / wb_err / wb_dat_r.
//   clk, rst_n : bus clock, async active-low reset
//   bus        : simplebus_host_if.master (Wishbone slave side + ext byte lanes)
//   TIMEOUT_CYCLES : WAIT_ACK cycles tolerated before erroring the request
module simplebus_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst_n,
  simplebus_host_if.master bus
);
  localparam int unsigned ADR_W  = 32;
  localparam int unsigned DAT_W  = 64;
  localparam int unsigned SEL_W  = 8;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TMO_W  = 16;

  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h03;
  localparam logic [BYTE_W-1:0] ACK_READ  = 8'h82;
  localparam logic [BYTE_W-1:0] ACK_WRITE = 8'h83;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_SEL, ST_WDATA, ST_WAIT_ACK, ST_RDATA, ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DAT_W-1:0]  wdat_q, wdat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              fail_q, fail_d;
  logic [BYTE_W-1:0] out_q, out_d;
  logic              pty_q, pty_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              stall_q, stall_d;
  logic [DAT_W-1:0]  rdat_q, rdat_d;
  logic              pty_ok_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      fail_q  <= 1'b0;
      out_q   <= '0;
      pty_q   <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      fail_q  <= fail_d;
      out_q   <= out_d;
      pty_q   <= pty_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      rdat_q  <= rdat_d;
    end
  end

  assign pty_ok_c = (bus.ext_bus_pty_in == ~^bus.ext_bus_in);

  // Next state, request latch, response decode and next bus byte
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    fail_d  = fail_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    out_d   = '0;

    case (state_q)
      ST_IDLE: begin
        // Hold off while the previous pulse is still visible so the same
        // request is not taken twice.
        if (bus.wb_cyc && bus.wb_stb && !ack_q && !err_q) begin
          we_d    = bus.wb_we;
          adr_d   = bus.wb_adr;
          wdat_d  = bus.wb_dat_w;
          sel_d   = bus.wb_sel;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        cnt_d   = '0;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (cnt_q == CNT_W'(3)) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = we_q ? ST_SEL : ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEL: begin
        cnt_d   = '0;
        state_d = ST_WDATA;
      end
      ST_WDATA: begin
        if (cnt_q == CNT_W'(7)) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (!pty_ok_c) begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end else if (bus.ext_bus_in == '0) begin
          if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            fail_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end else if (we_q && bus.ext_bus_in == ACK_WRITE) begin
          fail_d  = 1'b0;
          state_d = ST_DONE;
        end else if (!we_q && bus.ext_bus_in == ACK_READ) begin
          cnt_d   = '0;
          state_d = ST_RDATA;
        end else begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RDATA: begin
        if (!pty_ok_c) begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          // LSB-first bytes land in the top lane and shift down
          rdat_d = {bus.ext_bus_in, rdat_q[DAT_W-1:BYTE_W]};
          if (cnt_q == CNT_W'(7)) begin
            fail_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        // An abandoned cycle completes silently
        ack_d   = bus.wb_cyc && !fail_q;
        err_d   = bus.wb_cyc && fail_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus byte is registered against the state being entered
    case (state_d)
      ST_CMD:   out_d = we_d ? CMD_WRITE : CMD_READ;
      ST_ADDR:  out_d = BYTE_W'(adr_d >> {cnt_d[1:0], 3'b000});
      ST_SEL:   out_d = sel_d;
      ST_WDATA: out_d = BYTE_W'(wdat_d >> {cnt_d[2:0], 3'b000});
      default:  out_d = '0;
    endcase
    pty_d   = ~^out_d;
    stall_d = (state_d != ST_IDLE);
  end

  assign bus.ext_bus_out     = out_q;
  assign bus.ext_bus_pty_out = pty_q;
  assign bus.wb_ack          = ack_q;
  assign bus.wb_err          = err_q;
  assign bus.wb_stall        = stall_q;
  assign bus.wb_dat_r        = rdat_q;
endmodule

// File: tb/tb_simplebus_host.sv
// tb_simplebus_host: directed test-plan cases followed by random requests;
// a transaction-level model derives frames, response timing and read data.
module tb_simplebus_host;
  localparam int unsigned TMO = 16;
  localparam int K_OK  = 0;
  localparam int K_PTY = 1;
  localparam int K_BAD = 2;
  localparam int K_TMO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simplebus_host_if bus ();

  simplebus_host #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] mdl_rdat = 64'h0;
  logic        mdl_known = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full request: issue, check frame, play device response, check outcome
  task automatic run_xact(input logic we, input logic [31:0] adr, input logic [7:0] sel,
                          input logic [63:0] dat, input int kind, input int delay,
                          input int perr, input logic [63:0] rdat, input logic drop,
                          input logic [7:0] bad);
    logic [7:0] frame[$];
    logic [7:0] rsp[$];
    int exp_pulse;
    logic exp_err;
    int ack_cnt = 0;
    int err_cnt = 0;
    int pulse_at = -1;
    int nz = 0;
    logic [7:0] b;
    logic bp;

    frame.push_back(we ? 8'h03 : 8'h02);
    for (int i = 0; i < 4; i++) frame.push_back(adr[8*i +: 8]);
    if (we) begin
      frame.push_back(sel);
      for (int i = 0; i < 8; i++) frame.push_back(dat[8*i +: 8]);
    end

    if (kind == K_OK || kind == K_PTY) begin
      rsp.push_back(we ? 8'h83 : 8'h82);
      if (!we) for (int i = 0; i < 8; i++) rsp.push_back(rdat[8*i +: 8]);
    end else if (kind == K_BAD) begin
      rsp.push_back(bad);
    end

    // Byte driven at wait index j is sampled next edge; pulse follows DONE
    case (kind)
      K_OK:    begin exp_err = 1'b0; exp_pulse = delay + rsp.size() + 1; end
      K_PTY:   begin exp_err = 1'b1; exp_pulse = delay + perr + 2; end
      K_BAD:   begin exp_err = 1'b1; exp_pulse = delay + 2; end
      default: begin exp_err = 1'b1; exp_pulse = TMO + 1; end
    endcase

    @(negedge clk);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_adr   = adr;
    bus.wb_sel   = sel;
    bus.wb_dat_w = dat;
    @(posedge clk);
    foreach (frame[f]) begin
      @(negedge clk);
      if (f == 0) begin
        bus.wb_stb = 1'b0;
        check_eq("stall_busy", 64'(bus.wb_stall), 64'd1);
      end
      if (drop && f == 2) bus.wb_cyc = 1'b0;
      check_eq($sformatf("frame_byte%0d", f), 64'(bus.ext_bus_out), 64'(frame[f]));
      check_eq($sformatf("frame_pty%0d", f), 64'(bus.ext_bus_pty_out), 64'(~^frame[f]));
    end

    for (int j = 0; j <= exp_pulse + 3; j++) begin
      @(negedge clk);
      if (bus.wb_ack) begin ack_cnt++; pulse_at = j; end
      if (bus.wb_err) begin err_cnt++; pulse_at = j; end
      if (bus.ext_bus_out != 8'h00) nz++;
      if (j == 0) check_eq("stall_wait", 64'(bus.wb_stall), 64'd1);
      b  = 8'h00;
      bp = 1'b0;
      if (j >= delay && (j - delay) < rsp.size()) begin
        b  = rsp[j - delay];
        bp = (kind == K_PTY) && ((j - delay) == perr);
      end
      bus.ext_bus_in     = b;
      bus.ext_bus_pty_in = (~^b) ^ bp;
    end
    bus.wb_cyc = 1'b0;

    check_eq("ack_count", 64'(ack_cnt), (!drop && !exp_err) ? 64'd1 : 64'd0);
    check_eq("err_count", 64'(err_cnt), (!drop && exp_err) ? 64'd1 : 64'd0);
    if (!drop) check_eq("pulse_time", 64'(pulse_at), 64'(exp_pulse));
    check_eq("bus_quiet", 64'(nz), 64'd0);
    check_eq("stall_idle", 64'(bus.wb_stall), 64'd0);

    if (!we) begin
      if (kind == K_OK) begin
        mdl_rdat  = rdat;
        mdl_known = 1'b1;
      end else if (kind == K_PTY && perr >= 2) begin
        mdl_known = 1'b0;
      end
    end
    if (mdl_known) check_eq("dat_r", bus.wb_dat_r, mdl_rdat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    int kind;
    int perr;
    int errs;
    logic we;
    logic drop;
    logic [7:0] bad;

    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we = 1'b0;
    bus.wb_adr = '0;
    bus.wb_dat_w = '0;
    bus.wb_sel = '0;
    bus.ext_bus_in = 8'h00;
    bus.ext_bus_pty_in = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_bus", 64'(bus.ext_bus_out), 64'h0);
    check_eq("rst_pty", 64'(bus.ext_bus_pty_out), 64'd1);
    check_eq("rst_ack", 64'(bus.wb_ack), 64'd0);
    check_eq("rst_err", 64'(bus.wb_err), 64'd0);
    check_eq("rst_stall", 64'(bus.wb_stall), 64'd0);
    check_eq("rst_dat_r", bus.wb_dat_r, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xact(1'b1, 32'h12345678, 8'hFF, 64'h1122334455667788, K_OK, 3, 0, 64'h0, 1'b0, 8'h00);
    run_xact(1'b0, 32'hC0000000, 8'h00, 64'h0, K_OK, 8, 0, 64'h0102030405060708, 1'b0, 8'h00);
    run_xact(1'b0, 32'h00000040, 8'h00, 64'h0, K_PTY, 2, 3, 64'h8877665544332211, 1'b0, 8'h00);
    run_xact(1'b1, 32'h00000048, 8'h0F, 64'hDEADBEEFCAFEF00D, K_OK, 0, 0, 64'h0, 1'b0, 8'h00);
    run_xact(1'b0, 32'h10000000, 8'h00, 64'h0, K_TMO, 0, 0, 64'h0, 1'b0, 8'h00);
    run_xact(1'b1, 32'hA5A5A5A5, 8'h3C, 64'h0123456789ABCDEF, K_BAD, 1, 0, 64'h0, 1'b0, 8'h82);
    run_xact(1'b1, 32'h0BADF00D, 8'hAA, 64'hFEDCBA9876543210, K_OK, 4, 0, 64'h0, 1'b1, 8'h00);

    // Reset landing in the middle of write data
    @(negedge clk);
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
    bus.wb_adr = 32'h55AA55AA; bus.wb_sel = 8'hFF; bus.wb_dat_w = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.wb_stb = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_bus", 64'(bus.ext_bus_out), 64'h0);
    check_eq("midrst_pty", 64'(bus.ext_bus_pty_out), 64'd1);
    check_eq("midrst_stall", 64'(bus.wb_stall), 64'd0);
    bus.wb_cyc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.wb_ack || bus.wb_err || bus.ext_bus_out != 8'h00) errs++;
    end
    check_eq("midrst_quiet", 64'(errs), 64'd0);
    mdl_rdat  = 64'h0;
    mdl_known = 1'b1;
    run_xact(1'b0, 32'h00001000, 8'h00, 64'h0, K_OK, 5, 0, 64'h1357924680ACEBDF, 1'b0, 8'h00);

    for (int it = 0; it < 40; it++) begin
      we   = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 9));
      kind = (r <= 4 || r == 9) ? K_OK : (r <= 6) ? K_PTY : (r == 7) ? K_BAD : K_TMO;
      drop = (r == 9);
      perr = we ? 0 : int'($urandom_range(0, 8));
      do bad = 8'($urandom_range(1, 255)); while (bad == (we ? 8'h83 : 8'h82));
      run_xact(we, $urandom, 8'($urandom), {$urandom, $urandom}, kind,
               int'($urandom_range(0, 12)), perr, {$urandom, $urandom}, drop, bad);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
